// File: rtl/mbi5153_cmd_tx.sv
`timescale 1ns/1ps
// mbi5153_cmd_tx
// Serialises one 16-bit command word onto the MBI5153 SDI/DCLK/LE lines.
// A latched request from the upstream handshake FSM is accepted in IDLE and
// acknowledged with a one-cycle ACK. The word then shifts out MSB first, with
// LE high on the trailing CMD_LE DCLK clocks. A quiet gap follows, then a
// one-cycle DONE is returned.
// Ports:
//   CLK, RESET      : system clock, synchronous active-high reset
//   REQ             : request, held high until ACK
//   CMD_DATA        : word to shift (MSB first), sampled when REQ is accepted
//   CMD_LE          : number of trailing DCLK clocks with LE high (0..15)
//   ACK, DONE       : one-cycle pulses (accepted / finished)
//   BUSY            : high from the ACK cycle through the DONE cycle
//   DCLK, SDI, LE   : serial interface to the drivers
module mbi5153_cmd_tx #(
  parameter int unsigned DCLK_DIV = 2,
  parameter int unsigned DATA_W   = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              REQ,
  input  logic [DATA_W-1:0] CMD_DATA,
  input  logic [3:0]        CMD_LE,
  output logic              ACK,
  output logic              DONE,
  output logic              BUSY,
  output logic              DCLK,
  output logic              SDI,
  output logic              LE
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SHIFT_LO = 3'd1,
    SHIFT_HI = 3'd2,
    GAP      = 3'd3,
    FIN      = 3'd4
  } state_t;

  localparam logic [8:0] DIV_M1 = 9'(DCLK_DIV - 1);
  localparam logic [8:0] GAP_M1 = 9'(2 * DCLK_DIV - 1);

  state_t            state;
  logic [8:0]        cnt;
  logic [3:0]        idx;
  logic [DATA_W-1:0] shreg;
  logic [3:0]        le_n;

  // LE is high for bit i when i >= DATA_W - CMD_LE (5-bit sum avoids wrap).
  function automatic logic le_on(input logic [3:0] i, input logic [3:0] n);
    return ({1'b0, i} + {1'b0, n}) >= 5'(DATA_W);
  endfunction

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
      le_n  <= '0;
      ACK   <= 1'b0;
      DONE  <= 1'b0;
      BUSY  <= 1'b0;
      DCLK  <= 1'b0;
      SDI   <= 1'b0;
      LE    <= 1'b0;
    end else begin
      ACK  <= 1'b0;
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (REQ) begin
            // First bit is presented directly from the input; the shift
            // register keeps the remaining bits pre-shifted so its MSB is
            // always the next bit to send.
            shreg <= {CMD_DATA[DATA_W-2:0], 1'b0};
            le_n  <= CMD_LE;
            idx   <= '0;
            cnt   <= DIV_M1;
            ACK   <= 1'b1;
            BUSY  <= 1'b1;
            DCLK  <= 1'b0;
            SDI   <= CMD_DATA[DATA_W-1];
            LE    <= le_on(4'd0, CMD_LE);
            state <= SHIFT_LO;
          end
        end
        SHIFT_LO: begin
          if (cnt == '0) begin
            cnt   <= DIV_M1;
            DCLK  <= 1'b1;
            state <= SHIFT_HI;
          end else begin
            cnt <= cnt - 9'd1;
          end
        end
        SHIFT_HI: begin
          if (cnt == '0) begin
            DCLK <= 1'b0;
            if (idx != 4'(DATA_W - 1)) begin
              idx   <= idx + 4'd1;
              cnt   <= DIV_M1;
              SDI   <= shreg[DATA_W-1];
              shreg <= {shreg[DATA_W-2:0], 1'b0};
              LE    <= le_on(idx + 4'd1, le_n);
              state <= SHIFT_LO;
            end else begin
              cnt   <= GAP_M1;
              SDI   <= 1'b0;
              LE    <= 1'b0;
              state <= GAP;
            end
          end else begin
            cnt <= cnt - 9'd1;
          end
        end
        GAP: begin
          if (cnt == '0) begin
            DONE  <= 1'b1;
            state <= FIN;
          end else begin
            cnt <= cnt - 9'd1;
          end
        end
        FIN: begin
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          BUSY  <= 1'b0;
          DCLK  <= 1'b0;
          SDI   <= 1'b0;
          LE    <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mbi5153_cmd_tx.sv
`timescale 1ns/1ps
// Directed bench for mbi5153_cmd_tx: expected SDI/LE pairs are queued when a
// command is issued and checked on every observed DCLK rising edge.
module tb_mbi5153_cmd_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req2 = 1'b0, req1 = 1'b0;
  logic [15:0] cmd_data = '0;
  logic [3:0]  cmd_le = '0;
  logic        ack2, done2, busy2, dclk2, sdi2, le2;
  logic        ack1, done1, busy1, dclk1, sdi1, le1;
  bit          sel = 1'b0;   // 0: DCLK_DIV=2 instance, 1: DCLK_DIV=1 instance

  int total = 0;
  int bad = 0;
  int rises = 0;
  logic [1:0] exp_q[$];
  logic dclk_prev = 1'b0;

  always #5 clk = ~clk;

  mbi5153_cmd_tx #(.DCLK_DIV(2), .DATA_W(16)) u_div2 (
    .CLK(clk), .RESET(rst), .REQ(req2), .CMD_DATA(cmd_data), .CMD_LE(cmd_le),
    .ACK(ack2), .DONE(done2), .BUSY(busy2), .DCLK(dclk2), .SDI(sdi2), .LE(le2)
  );

  mbi5153_cmd_tx #(.DCLK_DIV(1), .DATA_W(16)) u_div1 (
    .CLK(clk), .RESET(rst), .REQ(req1), .CMD_DATA(cmd_data), .CMD_LE(cmd_le),
    .ACK(ack1), .DONE(done1), .BUSY(busy1), .DCLK(dclk1), .SDI(sdi1), .LE(le1)
  );

  logic m_ack, m_done, m_busy, m_dclk, m_sdi, m_le;
  assign m_ack  = sel ? ack1  : ack2;
  assign m_done = sel ? done1 : done2;
  assign m_busy = sel ? busy1 : busy2;
  assign m_dclk = sel ? dclk1 : dclk2;
  assign m_sdi  = sel ? sdi1  : sdi2;
  assign m_le   = sel ? le1   : le2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: one expected {SDI,LE} per DCLK rising edge.
  always @(negedge clk) begin
    if (m_dclk === 1'b1 && dclk_prev === 1'b0) begin
      rises++;
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL extra_rise observed=%0d expected=%0d", rises, 0);
      end
      if (exp_q.size() != 0) chk("sdi_le", 32'({m_sdi, m_le}), 32'(exp_q.pop_front()));
    end
    dclk_prev = m_dclk;
  end

  task automatic push_word(input logic [15:0] d, input logic [3:0] n);
    for (int i = 0; i < 16; i++)
      exp_q.push_back({d[15-i], logic'(i >= 16 - int'(n))});
  endtask

  task automatic set_req(input logic v);
    if (sel) req1 = v; else req2 = v;
  endtask

  // One full command with REQ accepted at the next edge (k=1 is the ACK cycle).
  task automatic xfer(input logic [15:0] d, input logic [3:0] n, input int div,
                      input bit disturb, input string tag);
    int rb, acks, ack_k, dones, done_k, first_rise, busy_bad, gap_bad;
    logic lp;
    rb = rises; acks = 0; ack_k = -1; dones = 0; done_k = -1;
    first_rise = -1; busy_bad = 0; gap_bad = 0; lp = m_dclk;
    push_word(d, n);
    cmd_data = d; cmd_le = n; set_req(1'b1);
    for (int k = 1; k <= 34 * div + 4; k++) begin
      @(posedge clk); #1;
      if (k == 1) set_req(1'b0);
      if (disturb) begin
        if (k == 2) begin cmd_data = ~d; cmd_le = ~n; end
        if (k == 20) set_req(1'b1);
        if (k == 22) set_req(1'b0);
      end
      if (m_ack) begin acks++; if (ack_k < 0) ack_k = k; end
      if (m_done) begin dones++; if (done_k < 0) done_k = k; end
      if (m_busy !== logic'(k <= 34 * div + 1)) busy_bad++;
      if (m_dclk && !lp && first_rise < 0) first_rise = k;
      lp = m_dclk;
      if (k > 32 * div && k <= 34 * div && {m_dclk, m_sdi, m_le} !== 3'b000) gap_bad++;
    end
    chk({tag, "_ack_cnt"}, acks, 1);
    chk({tag, "_ack_k"}, ack_k, 1);
    chk({tag, "_first_rise"}, first_rise, 1 + div);
    chk({tag, "_rises"}, rises - rb, 16);
    chk({tag, "_done_cnt"}, dones, 1);
    chk({tag, "_done_k"}, done_k, 34 * div + 1);
    chk({tag, "_busy_bad"}, busy_bad, 0);
    chk({tag, "_gap_bad"}, gap_bad, 0);
    chk({tag, "_q_left"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int rb, acks, dones;
    int ack_k[2], done_k[2];
    logic busy_gap;

    // 1. reset and idle
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_outs2", {ack2, done2, busy2, dclk2, sdi2, le2}, 0);
    chk("reset_outs1", {ack1, done1, busy1, dclk1, sdi1, le1}, 0);
    rb = rises; acks = 0;
    repeat (10) begin @(posedge clk); #1; if (ack1 | ack2) acks++; end
    chk("idle_ack", acks, 0);
    chk("idle_rises", rises - rb, 0);

    // 2. basic data-latch command
    sel = 1'b0;
    xfer(16'hA5C3, 4'd1, 2, 1'b0, "latch");
    // 3. LE lengths
    xfer(16'h1234, 4'd3, 2, 1'b0, "vsync");
    xfer(16'hF00F, 4'd11, 2, 1'b0, "config");
    xfer(16'h8001, 4'd14, 2, 1'b0, "preact");
    xfer(16'h5A5A, 4'd0, 2, 1'b0, "plain");
    xfer(16'hFFFF, 4'd15, 2, 1'b0, "le15");
    // 4. REQ pulse and input changes mid-transfer
    xfer(16'hC35A, 4'd3, 2, 1'b1, "disturb");

    // 5. reset during the 8th bit (8th rise visible at k=31 for DIV=2)
    push_word(16'h3C96, 4'd11);
    cmd_data = 16'h3C96; cmd_le = 4'd11; req2 = 1'b1;
    for (int k = 1; k <= 31; k++) begin
      @(posedge clk); #1;
      if (k == 1) req2 = 1'b0;
    end
    chk("rst_dclk_hi", m_dclk, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_outs", {m_ack, m_done, m_busy, m_dclk, m_sdi, m_le}, 0);
    chk("rst_q_left", exp_q.size(), 8);
    exp_q.delete();
    dones = 0;
    repeat (80) begin @(posedge clk); #1; if (m_done | m_busy | m_dclk) dones++; end
    chk("rst_quiet", dones, 0);
    xfer(16'h0F0F, 4'd3, 2, 1'b0, "post_rst");

    // 6. back-to-back with DIV=1, REQ held high
    sel = 1'b1;
    push_word(16'hA5C3, 4'd3);
    push_word(16'h6E17, 4'd11);
    rb = rises; acks = 0; dones = 0; busy_gap = 1'bx;
    ack_k = '{-1, -1}; done_k = '{-1, -1};
    cmd_data = 16'hA5C3; cmd_le = 4'd3; req1 = 1'b1;
    for (int k = 1; k <= 80; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin cmd_data = 16'h6E17; cmd_le = 4'd11; end
      if (m_ack) begin if (acks < 2) ack_k[acks] = k; acks++; end
      if (m_done) begin if (dones < 2) done_k[dones] = k; dones++; end
      if (k == 36) busy_gap = m_busy;
      if (acks == 2) req1 = 1'b0;
    end
    chk("b2b_acks", acks, 2);
    chk("b2b_ack0", ack_k[0], 1);
    chk("b2b_ack1", ack_k[1], 37);
    chk("b2b_dones", dones, 2);
    chk("b2b_done0", done_k[0], 35);
    chk("b2b_done1", done_k[1], 71);
    chk("b2b_busy_gap", busy_gap, 0);
    chk("b2b_rises", rises - rb, 32);
    chk("b2b_q_left", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
